// File: rtl/rf_read_arbiter_if.sv
// rf_read_arbiter_if
// Groups the request, read-mux and response signals of the register-file
// read arbiter.
//   req_valid/req_addr/req_ready : per-requester valid/ready read requests
//   hold                         : freezes new grants while high
//   mux_sel/mux_data             : selector to and data from the 32:1 read mux
//   rsp_valid/rsp_data           : one-hot response strobe and captured word
// master: requester/mux side, slave: the arbiter.
interface rf_read_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32
);
    logic [NREQ-1:0]   req_valid;
    logic [5*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic              hold;
    logic [4:0]        mux_sel;
    logic [DW-1:0]     mux_data;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;

    modport master (
        output req_valid, req_addr, hold, mux_data,
        input  req_ready, mux_sel, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, hold, mux_data,
        output req_ready, mux_sel, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
// Round-robin arbiter sharing the single 32:1 general-register read mux among
// NREQ requesters. A grant registers the 5-bit mux selector; the selected word
// is captured one cycle later and returned with a one-hot response strobe.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : rf_read_arbiter_if slave modport (requests, mux, responses)
module rf_read_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    rf_read_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]  rr_q, rr_d;
    logic [4:0]      mux_sel_q, mux_sel_d;
    logic            s1_valid_q, s1_valid_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] grant_s;
    logic            grant_any_s;
    logic [IDW-1:0]  grant_id_s;
    logic [IDW:0]    sum_s;
    logic [IDW-1:0]  cand_s;
    logic            take_s;
    logic            stall_s;
    logic [4:0]      sel_addr_s;

    // Round-robin search starting at rr; the first valid candidate wins.
    // Candidates are visited in rotated order so each bit of grant_s is
    // written exactly once per evaluation.
    always_comb begin
        grant_s     = '0;
        grant_any_s = 1'b0;
        grant_id_s  = '0;
        sum_s       = '0;
        cand_s      = '0;
        take_s      = 1'b0;
        stall_s     = reset | bus.hold;
        for (int k = 0; k < NREQ; k++) begin
            sum_s  = {1'b0, rr_q} + (IDW+1)'(k);
            cand_s = (sum_s >= (IDW+1)'(NREQ)) ? IDW'(sum_s - (IDW+1)'(NREQ))
                                               : sum_s[IDW-1:0];
            take_s = bus.req_valid[cand_s] & ~grant_any_s & ~stall_s;
            grant_s[cand_s] = take_s;
            grant_id_s  = take_s ? cand_s : grant_id_s;
            grant_any_s = grant_any_s | take_s;
        end
    end

    // One-hot AND-OR select of the granted requester's register number.
    always_comb begin
        sel_addr_s = 5'd0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s = sel_addr_s | (bus.req_addr[i*5 +: 5] & {5{grant_s[i]}});
        end
    end

    // Next-state for the grant stage and the response stage.
    always_comb begin
        rr_d       = rr_q;
        mux_sel_d  = mux_sel_q;
        s1_valid_d = 1'b0;
        s1_id_d    = s1_id_q;
        if (grant_any_s) begin
            mux_sel_d  = sel_addr_s;
            s1_valid_d = 1'b1;
            s1_id_d    = grant_id_s;
            rr_d       = (grant_id_s == IDW'(NREQ-1)) ? '0 : grant_id_s + IDW'(1);
        end else begin
            rr_d       = rr_q;
            mux_sel_d  = mux_sel_q;
        end
        // GR0 is hardwired to zero whatever the mux presents.
        rsp_valid_d = s1_valid_q ? (NREQ'(1) << s1_id_q) : '0;
        rsp_data_d  = s1_valid_q ? ((mux_sel_q == 5'd0) ? '0 : bus.mux_data)
                                 : rsp_data_q;
    end

    // State registers; reset drops any in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q        <= '0;
            mux_sel_q   <= 5'd0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_q        <= rr_d;
            mux_sel_q   <= mux_sel_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
